pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
Instruction sequencer for the picoMIPS core. It owns the program counter and decides each cycle whether the PC increments, loads a branch target, or holds. Holds cover stalls for switch-input handshakes, multi-cycle multiply and halt. It sits between the instruction decoder (op class, branch condition) and the program memory address, and it gates the register-file write enable.

Parameters:
Psize, 6, program counter / program memory address width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
op_class  input  3  decoded class of instruction at pc_out (op_class_t)
br_cond  input  1  branch condition from ALU flags, valid with OP_BRANCH
br_target  input  Psize  absolute branch target address
in_valid  input  1  external input handshake (SW8-style, level)
mul_done  input  1  multiplier result ready, single-cycle pulse
pc_out  output  Psize  current program counter, registered
reg_we  output  1  register-file write enable for current instruction
in_ack  output  1  input accepted this cycle
mul_start  output  1  start pulse to multiplier
halted  output  1  sequencer stopped

Behaviour:
- Reset (sync, highest priority in every state):
  - pc_out=0, state=RUN, halted=0.
  - reg_we, in_ack and mul_start deasserted the same cycle reset is high.
- Output timing:
  - reg_we, in_ack and mul_start are Mealy (combinational from state + inputs), valid in the cycle the instruction is at pc_out.
  - pc_out updates on the following edge.
  - halted is decoded from state.
- RUN, per op_class:
  - OP_ALU: reg_we=1, pc<=pc+1. Throughput is 1 instruction/cycle.
  - OP_BRANCH: reg_we=0. If br_cond=1, pc<=br_target; otherwise pc<=pc+1.
  - OP_READ, in_valid=1: reg_we=1, in_ack=1, pc<=pc+1, ->WAIT_REL.
  - OP_READ, in_valid=0: pc holds, ->WAIT_IN.
  - OP_MUL: mul_start=1 for exactly one cycle, pc holds, ->MUL_BUSY.
  - OP_HALT: pc holds, ->HALTED.
  - Reserved codes 5-7: treated as NOP (pc<=pc+1, reg_we=0).
- WAIT_IN: pc holds, no writes. On in_valid=1: reg_we=1, in_ack=1, pc<=pc+1, ->WAIT_REL.
- WAIT_REL: pc holds (already advanced), no instruction executes. On in_valid=0: ->RUN. This prevents one switch press being read twice.
- MUL_BUSY: pc holds. On mul_done=1: reg_we=1, pc<=pc+1, ->RUN. mul_start is never reissued.
- HALTED: halted=1, pc holds, all enables 0. Only reset exits.
- Ignored inputs:
  - mul_done outside MUL_BUSY.
  - in_valid outside RUN/WAIT_IN/WAIT_REL.
  - br_cond/br_target unless OP_BRANCH in RUN.
- Arithmetic: pc+1 is modulo 2^Psize, so 2^Psize-1 wraps to 0. br_target is used unmodified.
- Reset during WAIT_IN/WAIT_REL/MUL_BUSY aborts the operation: no reg_we, no in_ack.

Optional Feature:
Macro PC_SEQ_STEP_EN.
- Defined: adds input port step (1 bit). In RUN, an instruction executes (including all enables and state changes) only in cycles with step=1. Otherwise the pc holds and all enables are 0. Wait states are unaffected by step.
- Undefined: no step port; RUN executes every cycle.

Decomposition:
- Package pico_seq_pkg:
  - op_class_t enum (OP_ALU=0, OP_BRANCH=1, OP_READ=2, OP_MUL=3, OP_HALT=4).
  - seq_state_t enum (RUN, WAIT_IN, WAIT_REL, MUL_BUSY, HALTED).
- Single optional sub-module pc_next_mux: combinational next-PC select (hold / +1 / target), reusable by the pipelined variant.
- The FSM and the PC register stay in pc_seq.

Test Plan:
- Reset, then 3 cycles OP_ALU -> pc_out 0,1,2,3; reg_we=1 each cycle; halted=0.
- Branch tests:
  - At pc=3, OP_BRANCH, br_cond=1, br_target=6'h2A -> pc_out=42 next cycle, reg_we=0.
  - Repeat with br_cond=0 -> pc_out=4.
- Input handshake:
  - At pc=5, OP_READ with in_valid=0 for 4 cycles -> pc holds 5, in_ack=0.
  - in_valid=1 -> in_ack=1, reg_we=1 that cycle; pc_out=6.
  - in_valid held high 3 more cycles -> pc stays 6, no second ack.
  - in_valid=0 -> RUN resumes.
- Multiply: OP_MUL at pc=8 -> mul_start high 1 cycle; mul_done after 3 cycles -> reg_we=1 that cycle, pc_out=9 next; mul_start not re-pulsed.
- Wrap and halt:
  - pc=63 with OP_ALU -> pc_out=0.
  - OP_HALT -> halted=1, pc frozen through 10 cycles of OP_ALU; reset -> pc_out=0, halted=0.
- Reset mid-MUL_BUSY at pc=20, with mul_done asserted the same cycle -> pc_out=0, state RUN, reg_we=0.

Source files
------------

// File: rtl/pico_seq_pkg.sv
// Shared types for the picoMIPS instruction sequencer: op classes, FSM states, next-PC select.
package pico_seq_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ALU    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_READ   = 3'd2,
    OP_MUL    = 3'd3,
    OP_HALT   = 3'd4
  } op_class_t;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 3'd0,
    WAIT_IN  = 3'd1,
    WAIT_REL = 3'd2,
    MUL_BUSY = 3'd3,
    HALTED   = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: hold, increment (wraps modulo 2^Psize) or absolute target.
module pc_next_mux
  import pico_seq_pkg::*;
#(
  parameter int unsigned Psize = 6
) (
  input  pc_sel_t          sel,
  input  logic [Psize-1:0] pc,
  input  logic [Psize-1:0] target,
  output logic [Psize-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    unique case (sel)
      PC_INC:  pc_next = pc + Psize'(1);
      PC_LOAD: pc_next = target;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_seq.sv
// picoMIPS sequencer: owns the PC, stalls for switch input / multiply / halt, gates reg_we.
// Optional build macro PC_SEQ_STEP_EN adds a 'step' input that gates execution in RUN.
module pc_seq
  import pico_seq_pkg::*;
#(
  parameter int unsigned Psize = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op_class,
  input  logic             br_cond,
  input  logic [Psize-1:0] br_target,
  input  logic             in_valid,
  input  logic             mul_done,
`ifdef PC_SEQ_STEP_EN
  input  logic             step,
`endif
  output logic [Psize-1:0] pc_out,
  output logic             reg_we,
  output logic             in_ack,
  output logic             mul_start,
  output logic             halted
);

  seq_state_t       state, state_nxt;
  pc_sel_t          sel;
  logic [Psize-1:0] pc_nxt;
  logic             exec;
  op_class_t        opc;

  assign opc = op_class_t'(op_class);

`ifdef PC_SEQ_STEP_EN
  assign exec = step;
`else
  assign exec = 1'b1;
`endif

  pc_next_mux #(.Psize(Psize)) u_mux (
    .sel     (sel),
    .pc      (pc_out),
    .target  (br_target),
    .pc_next (pc_nxt)
  );

  // State and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      pc_out <= '0;
    end else begin
      state  <= state_nxt;
      pc_out <= pc_nxt;
    end
  end

  // Next state, PC select and Mealy enables; reset suppresses every enable
  always_comb begin
    state_nxt = state;
    sel       = PC_HOLD;
    reg_we    = 1'b0;
    in_ack    = 1'b0;
    mul_start = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (exec) begin
            unique case (opc)
              OP_ALU: begin
                reg_we = 1'b1;
                sel    = PC_INC;
              end
              OP_BRANCH: sel = br_cond ? PC_LOAD : PC_INC;
              OP_READ: begin
                if (in_valid) begin
                  reg_we    = 1'b1;
                  in_ack    = 1'b1;
                  sel       = PC_INC;
                  state_nxt = WAIT_REL;
                end else begin
                  state_nxt = WAIT_IN;
                end
              end
              OP_MUL: begin
                mul_start = 1'b1;
                state_nxt = MUL_BUSY;
              end
              OP_HALT: state_nxt = HALTED;
              default: sel = PC_INC;
            endcase
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            reg_we    = 1'b1;
            in_ack    = 1'b1;
            sel       = PC_INC;
            state_nxt = WAIT_REL;
          end
        end
        // Wait for switch release so one press is read once
        WAIT_REL: if (!in_valid) state_nxt = RUN;
        MUL_BUSY: begin
          if (mul_done) begin
            reg_we    = 1'b1;
            sel       = PC_INC;
            state_nxt = RUN;
          end
        end
        HALTED:  state_nxt = HALTED;
        default: state_nxt = RUN;
      endcase
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed test-plan steps then random ops vs a behavioural model.
module tb_pc_seq;
  import pico_seq_pkg::*;

  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    op_class;
  logic          br_cond;
  logic [PW-1:0] br_target;
  logic          in_valid;
  logic          mul_done;
  logic [PW-1:0] pc_out;
  logic          reg_we, in_ack, mul_start, halted;
`ifdef PC_SEQ_STEP_EN
  logic          step = 1'b1;
`endif

  pc_seq #(.Psize(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_class  (op_class),
    .br_cond   (br_cond),
    .br_target (br_target),
    .in_valid  (in_valid),
    .mul_done  (mul_done),
`ifdef PC_SEQ_STEP_EN
    .step      (step),
`endif
    .pc_out    (pc_out),
    .reg_we    (reg_we),
    .in_ack    (in_ack),
    .mul_start (mul_start),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: program counter and what the sequencer is waiting for
  int m_pc   = 0;
  int m_wait = 0; // 0 none, 1 switch press, 2 switch release, 3 multiplier, 4 halted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check Mealy outputs, clock, check PC/halted.
  task automatic cyc(input string tag, input logic rst, input logic [2:0] op, input logic c,
                     input logic [PW-1:0] t, input logic iv, input logic md);
    int n_pc, n_wait;
    logic e_we, e_ack, e_ms;
    reset = rst; op_class = op; br_cond = c; br_target = t; in_valid = iv; mul_done = md;
    #1;
    e_we = 1'b0; e_ack = 1'b0; e_ms = 1'b0;
    n_pc = m_pc; n_wait = m_wait;
    if (rst) begin
      n_pc = 0; n_wait = 0;
    end else if (m_wait == 0) begin
      if (op == 3'd0) begin e_we = 1'b1; n_pc = m_pc + 1; end
      else if (op == 3'd1) n_pc = c ? int'(t) : m_pc + 1;
      else if (op == 3'd2) begin
        if (iv) begin e_we = 1'b1; e_ack = 1'b1; n_pc = m_pc + 1; n_wait = 2; end
        else n_wait = 1;
      end
      else if (op == 3'd3) begin e_ms = 1'b1; n_wait = 3; end
      else if (op == 3'd4) n_wait = 4;
      else n_pc = m_pc + 1;
    end else if (m_wait == 1) begin
      if (iv) begin e_we = 1'b1; e_ack = 1'b1; n_pc = m_pc + 1; n_wait = 2; end
    end else if (m_wait == 2) begin
      if (!iv) n_wait = 0;
    end else if (m_wait == 3) begin
      if (md) begin e_we = 1'b1; n_pc = m_pc + 1; n_wait = 0; end
    end
    chk({tag, ".reg_we"}, 32'(reg_we), 32'(e_we));
    chk({tag, ".in_ack"}, 32'(in_ack), 32'(e_ack));
    chk({tag, ".mul_start"}, 32'(mul_start), 32'(e_ms));
    @(posedge clk);
    m_pc = n_pc % 64; m_wait = n_wait;
    #1;
    chk({tag, ".pc"}, 32'(pc_out), 32'(m_pc));
    chk({tag, ".halted"}, 32'(halted), 32'(m_wait == 4));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; op_class = 3'd0; br_cond = 1'b0; br_target = '0; in_valid = 1'b0; mul_done = 1'b0;
    @(negedge clk);
    cyc("reset", 1'b1, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("reset_pc", 32'(pc_out), 32'd0);
    for (int i = 0; i < 3; i++) cyc("alu", 1'b0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("alu_pc3", 32'(pc_out), 32'd3);
    cyc("br_taken", 1'b0, 3'd1, 1'b1, 6'h2A, 1'b0, 1'b0);
    chk("br_taken_pc", 32'(pc_out), 32'd42);
    cyc("br_back", 1'b0, 3'd1, 1'b1, 6'd3, 1'b0, 1'b0);
    cyc("br_not", 1'b0, 3'd1, 1'b0, 6'h2A, 1'b0, 1'b0);
    chk("br_not_pc", 32'(pc_out), 32'd4);
    cyc("alu5", 1'b0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("rd_wait", 1'b0, 3'd2, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("rd_hold_pc", 32'(pc_out), 32'd5);
    cyc("rd_go", 1'b0, 3'd2, 1'b0, 6'd0, 1'b1, 1'b0);
    chk("rd_go_pc", 32'(pc_out), 32'd6);
    for (int i = 0; i < 3; i++) cyc("rd_rel", 1'b0, 3'd2, 1'b0, 6'd0, 1'b1, 1'b0);
    cyc("rd_drop", 1'b0, 3'd2, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("alu_run", 1'b0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("pre_mul_pc", 32'(pc_out), 32'd8);
    cyc("mul_go", 1'b0, 3'd3, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("mul_busy", 1'b0, 3'd3, 1'b0, 6'd0, 1'b0, 1'b0);
    cyc("mul_done", 1'b0, 3'd3, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("mul_pc", 32'(pc_out), 32'd9);
    cyc("to63", 1'b0, 3'd1, 1'b1, 6'd63, 1'b0, 1'b0);
    cyc("wrap", 1'b0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("wrap_pc", 32'(pc_out), 32'd0);
    cyc("rsvd", 1'b0, 3'd6, 1'b1, 6'd30, 1'b0, 1'b0);
    cyc("halt", 1'b0, 3'd4, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc("halted", 1'b0, 3'd0, 1'b1, 6'd9, 1'b1, 1'b1);
    chk("halt_pc", 32'(pc_out), 32'd1);
    cyc("halt_rst", 1'b1, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    cyc("to20", 1'b0, 3'd1, 1'b1, 6'd20, 1'b0, 1'b0);
    cyc("mul20", 1'b0, 3'd3, 1'b0, 6'd0, 1'b0, 1'b0);
    cyc("mul20_busy", 1'b0, 3'd3, 1'b0, 6'd0, 1'b0, 1'b0);
    cyc("mul20_rst", 1'b1, 3'd3, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("mul_rst_pc", 32'(pc_out), 32'd0);
    cyc("after_rst", 1'b0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("after_rst_pc", 32'(pc_out), 32'd1);
    // Random soak against the model
    for (int i = 0; i < 400; i++)
      cyc("rand", ($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7)), 1'($urandom),
          6'($urandom), 1'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
